uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Synchronous transmit buffer that sits directly upstream of the UART transmitter, between the bus-side register interface and the serialiser.
- Accepts bytes on an AXI4-Stream slave and presents them in order on an AXI4-Stream master that feeds the transmitter's s_axis port.
- Reports fill level and full/empty status for the uartlite status register, and supports a synchronous flush.

Parameters:
- DATA_WIDTH, 8, width of tdata on both stream ports.
- DEPTH_LOG2, 4, log2 of total capacity; capacity DEPTH = 2**DEPTH_LOG2 entries, output register included.

Ports:
- clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  input  1  synchronous active-high reset.
- s_axis_tdata  input  DATA_WIDTH  byte to enqueue.
- s_axis_tvalid  input  1  enqueue request.
- s_axis_tready  output  1  space available.
- m_axis_tdata  output  DATA_WIDTH  head-of-queue byte to the transmitter.
- m_axis_tvalid  output  1  head valid.
- m_axis_tready  input  1  transmitter accepts head.
- flush  input  1  synchronous clear of all contents.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset values:
  - s_axis_tready = 1, m_axis_tvalid = 0, m_axis_tdata = 0.
  - count = 0, full = 0, empty = 1.
  - Read and write pointers = 0.
- Storage:
  - RAM of DEPTH-1 entries plus one output register driving m_axis_tdata/m_axis_tvalid.
  - Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH-1.
- Push: occurs when s_axis_tvalid && s_axis_tready at a clock edge.
- Pop: occurs when m_axis_tvalid && m_axis_tready at a clock edge.
- Handshake outputs:
  - s_axis_tready = !full && !flush. It does not depend on m_axis_tready, so no combinational path exists from m to s.
  - full, empty and count are registered, or derived only from registered state.
- Latency: a byte pushed into an empty FIFO appears on m_axis with tvalid = 1 on the cycle after the push edge.
- Ordering: strict FIFO order. m_axis_tdata and m_axis_tvalid are held stable while tvalid && !tready. The transmitter deasserts and reasserts tready between frames; this must not cause loss or duplication.
- Output register refill:
  - When the output register is empty or popping, it loads the RAM head if the RAM is non-empty.
  - If the RAM is empty and a push occurs in that cycle, it loads s_axis_tdata directly (bypass).
- count update: next count = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - At count == DEPTH, push is blocked, so a pop alone gives DEPTH-1.
  - At count == 0, pop is impossible because tvalid = 0.
- flush:
  - Takes effect at the edge: pointers = 0, count = 0, m_axis_tvalid = 0.
  - flush has priority over push and pop in the same cycle; the pop handshake in that cycle is still seen by the consumer, and the data is discarded.
- Reset mid-operation: all contents are discarded and the reset values above apply on the next cycle. No partial byte is ever presented.

Optional Feature:
- Macro: UART_TX_FIFO_THRESH_EN.
- When defined, the block adds:
  - Input thresh, DEPTH_LOG2+1 bits.
  - Output thresh_irq, 1 bit, registered, reset 0.
- thresh_irq behaviour:
  - Pulses high for exactly one cycle when count transitions from > thresh to <= thresh. This is the "TX almost empty, refill" interrupt.
  - No pulse during flush or reset; flush forces thresh_irq = 0 that cycle.
- When not defined, these ports are absent and the related logic is not elaborated.

Decomposition:
- Shared package uart_pkg: DATA_WIDTH default constant, count width function clog2-based, and the stream beat struct (tdata only).
- One sub-module: uart_fifo_ram, a simple dual-port RAM with synchronous write and asynchronous read, parameterised by width and depth.
- Pointer, count and output-register control stay in uart_tx_fifo.

Test Plan:
- Push 0x41, 0x42, 0x43 with m_axis_tready = 0 -> count = 3, tvalid = 1 one cycle after the first push, tdata = 0x41 stable. Then raise tready -> 0x41, 0x42, 0x43 pop in order and count returns to 0.
- Push 16 bytes (0x00..0x0F), DEPTH_LOG2 = 4, tready = 0 -> full = 1 and s_axis_tready = 0 at count 16. The 17th beat (0xFF) is not accepted. Drain -> 0x00..0x0F exact, empty = 1.
- Continuous push and pop at full rate from empty, 100 random bytes -> output sequence equals input, count stays at most 2, bypass path exercised.
- At count = 5, assert flush together with s_axis_tvalid (0x55) -> next cycle count = 0, m_axis_tvalid = 0, 0x55 not stored.
- Assert rst at count = 7 mid-drain -> next cycle count = 0, empty = 1, s_axis_tready = 1, tvalid = 0. A later push of 0xA5 emerges alone.
- With UART_TX_FIFO_THRESH_EN defined and thresh = 2, fill to 4 and drain -> thresh_irq is a single 1-cycle pulse on the 3->2 transition, with no pulse on refill past 2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, counter sizing helper and
// the stream beat type used on the byte streams.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int uart_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [UART_DATA_WIDTH-1:0] tdata;
    } uart_beat_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Holds the queue body behind the transmit FIFO's output register.
module uart_fifo_ram #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Write port; contents need no reset since pointers gate all reads.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the register interface and the UART serialiser.
// Body RAM of DEPTH-1 entries plus an output register on m_axis; an empty
// FIFO bypasses the RAM so a byte appears one cycle after it is pushed.
// Optional: define UART_TX_FIFO_THRESH_EN for the "almost empty" interrupt.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef UART_TX_FIFO_THRESH_EN
    input  logic [DEPTH_LOG2:0]   thresh,
    output logic                  thresh_irq,
`endif
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int CW      = uart_cnt_width(DEPTH);
    localparam int AW      = DEPTH_LOG2;
    localparam int ENTRIES = DEPTH - 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(ENTRIES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  push, pop, ram_empty, load_out, ram_we;

    uart_fifo_ram #(
        .WIDTH   (DATA_WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (s_axis_tdata),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    // Handshakes, RAM/bypass steering and next-state for pointers, count, head.
    always_comb begin
        push       = s_axis_tvalid && s_axis_tready;
        pop        = out_vld_q && m_axis_tready;
        // RAM occupancy is total occupancy minus the output register.
        ram_empty  = (count_q == {{(CW-1){1'b0}}, out_vld_q});
        load_out   = !out_vld_q || pop;
        // A push into an empty RAM while the head is being replaced goes
        // straight to the output register instead of the RAM.
        ram_we     = push && !(load_out && ram_empty);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        if (ram_we) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        if (load_out) begin
            if (!ram_empty) begin
                out_data_d = ram_rdata;
                out_vld_d  = 1'b1;
                rptr_d     = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            end else if (push) begin
                out_data_d = s_axis_tdata;
                out_vld_d  = 1'b1;
            end else begin
                out_vld_d  = 1'b0;
            end
        end
    end

    // State registers; reset and flush both discard everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign s_axis_tready = !full_q && !flush;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_vld_q;
    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;

`ifdef UART_TX_FIFO_THRESH_EN
    logic irq_q, irq_d;

    // Falling-edge detect of occupancy across the threshold.
    always_comb begin
        irq_d = (count_q > thresh) && (count_d <= thresh);
    end

    // Interrupt pulse register, suppressed by flush.
    always_ff @(posedge clk) begin
        if (rst || flush) irq_q <= 1'b0;
        else              irq_q <= irq_d;
    end

    assign thresh_irq = irq_q;
`endif

endmodule
